// File: rtl/fnd_pkg.sv
// Shared glyph constants and font width for the 7-segment scan display.
// Latency: none (constants only).
// Backpressure: not applicable.
package fnd_pkg;

    localparam int FONT_W = 8;
    localparam int DP_BIT = 7;

    typedef logic [FONT_W-1:0] font_t;

    // Segment order {dp,g,f,e,d,c,b,a}, active-low, dp off in every glyph.
    localparam font_t GLYPH_0     = 8'hC0;
    localparam font_t GLYPH_1     = 8'hF9;
    localparam font_t GLYPH_2     = 8'hA4;
    localparam font_t GLYPH_3     = 8'hB0;
    localparam font_t GLYPH_4     = 8'h99;
    localparam font_t GLYPH_5     = 8'h92;
    localparam font_t GLYPH_6     = 8'h82;
    localparam font_t GLYPH_7     = 8'hF8;
    localparam font_t GLYPH_8     = 8'h80;
    localparam font_t GLYPH_9     = 8'h90;
    localparam font_t GLYPH_A     = 8'h88;
    localparam font_t GLYPH_B     = 8'h83;
    localparam font_t GLYPH_C     = 8'hC6;
    localparam font_t GLYPH_D     = 8'hA1;
    localparam font_t GLYPH_E     = 8'h86;
    localparam font_t GLYPH_F     = 8'h8E;
    localparam font_t GLYPH_BLANK = 8'hFF;

endpackage

// File: rtl/fnd_scan_controller_if.sv
// Display bus: enable, packed digit codes, dp requests in; segments and commons out.
// Latency: not applicable (signal bundle).
// Backpressure: none; the display consumes inputs continuously.
interface fnd_scan_controller_if #(
    parameter int DIGITS = 4
);
    import fnd_pkg::*;

    logic                  i_En;
    logic [4*DIGITS-1:0]   i_Value;
    logic [DIGITS-1:0]     i_Dp;
    logic [FONT_W-1:0]     o_FND_Font;
    logic [DIGITS-1:0]     o_FND_Com;

    // Master drives the display content and observes the pins.
    modport master (
        output i_En, i_Value, i_Dp,
        input  o_FND_Font, o_FND_Com
    );

    // Slave is the scan controller itself.
    modport slave (
        input  i_En, i_Value, i_Dp,
        output o_FND_Font, o_FND_Com
    );

endinterface

// File: rtl/fnd_glyph_lut.sv
// Combinational map from a 4-bit digit code to an active-low 7-segment font.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module fnd_glyph_lut
    import fnd_pkg::*;
#(
    parameter int HEX_MODE = 0
) (
    input  logic [3:0] code,
    output font_t      font
);

    localparam bit SHOW_HEX = (HEX_MODE != 0);

    // Decimal codes always map to glyphs; A..F only when hex display is enabled.
    always_comb begin
        font = GLYPH_BLANK;
        case (code)
            4'h0: font = GLYPH_0;
            4'h1: font = GLYPH_1;
            4'h2: font = GLYPH_2;
            4'h3: font = GLYPH_3;
            4'h4: font = GLYPH_4;
            4'h5: font = GLYPH_5;
            4'h6: font = GLYPH_6;
            4'h7: font = GLYPH_7;
            4'h8: font = GLYPH_8;
            4'h9: font = GLYPH_9;
            4'hA: font = SHOW_HEX ? GLYPH_A : GLYPH_BLANK;
            4'hB: font = SHOW_HEX ? GLYPH_B : GLYPH_BLANK;
            4'hC: font = SHOW_HEX ? GLYPH_C : GLYPH_BLANK;
            4'hD: font = SHOW_HEX ? GLYPH_D : GLYPH_BLANK;
            4'hE: font = SHOW_HEX ? GLYPH_E : GLYPH_BLANK;
            4'hF: font = SHOW_HEX ? GLYPH_F : GLYPH_BLANK;
            default: font = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/fnd_scan_controller.sv
// Multiplexed 7-segment scanner; optional leading-zero blanking via FND_LEADING_ZERO_BLANK_EN.
// Latency: outputs registered, reflect the digit index 1 cycle after it changes.
// Backpressure: none; input value is sampled per frame (or continuously while disabled).
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 100000,
    parameter int HEX_MODE = 0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    fnd_scan_controller_if.slave  bus
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(DIGITS);

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [4*DIGITS-1:0]   snap_val;
    logic [DIGITS-1:0]     snap_dp;
    logic                  tick;
    logic                  last_digit;
    logic                  wrap;
    logic [3:0]            cur_code;
    logic                  cur_dp;
    font_t                 lut_font;
    font_t                 glyph;
    font_t                 font_nxt;
    logic [DIGITS-1:0]     com_nxt;
    font_t                 font_q;
    logic [DIGITS-1:0]     com_q;

    assign tick       = (cnt == CNT_W'(SCAN_DIV - 1));
    assign last_digit = (idx == IDX_W'(DIGITS - 1));
    assign wrap       = tick && last_digit;

    // Prescaler and digit index; both parked at zero while the display is off.
    always_ff @(posedge i_clk) begin
        if (i_reset || !bus.i_En) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= last_digit ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Snapshot only at frame boundaries so a frame never mixes two input values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            snap_val <= '0;
            snap_dp  <= '0;
        end else if (!bus.i_En || wrap) begin
            snap_val <= bus.i_Value;
            snap_dp  <= bus.i_Dp;
        end
    end

    assign cur_code = snap_val[4*idx +: 4];
    assign cur_dp   = snap_dp[idx];

    fnd_glyph_lut #(
        .HEX_MODE (HEX_MODE)
    ) u_glyph_lut (
        .code (cur_code),
        .font (lut_font)
    );

`ifdef FND_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] lz_blank;

    // Digit k blanks when it and everything above it is zero; a lit dp keeps it visible.
    always_comb begin
        lz_blank = '0;
        for (int k = 1; k < DIGITS; k++) begin
            lz_blank[k] = ((snap_val >> (4*k)) == '0) && !snap_dp[k];
        end
    end

    assign glyph = lz_blank[idx] ? GLYPH_BLANK : lut_font;
`else
    assign glyph = lut_font;
`endif

    // Next-cycle pin values for the current digit; dp overrides even a blank glyph.
    always_comb begin
        font_nxt         = glyph;
        font_nxt[DP_BIT] = glyph[DP_BIT] & ~cur_dp;
        com_nxt          = '1;
        com_nxt[idx]     = 1'b0;
    end

    // Output registers; dark display on reset or when disabled.
    always_ff @(posedge i_clk) begin
        if (i_reset || !bus.i_En) begin
            font_q <= GLYPH_BLANK;
            com_q  <= '1;
        end else begin
            font_q <= font_nxt;
            com_q  <= com_nxt;
        end
    end

    assign bus.o_FND_Font = font_q;
    assign bus.o_FND_Com  = com_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench for fnd_scan_controller (DIGITS=4, SCAN_DIV=4).
// Latency: expects pin changes 1 cycle after each index change.
// Backpressure: not applicable.
module tb_fnd_scan_controller;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fnd_scan_controller_if #(.DIGITS(4)) bus  ();
    fnd_scan_controller_if #(.DIGITS(4)) hbus ();

    fnd_scan_controller #(
        .DIGITS   (4),
        .SCAN_DIV (4),
        .HEX_MODE (0)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    fnd_scan_controller #(
        .DIGITS   (4),
        .SCAN_DIV (4),
        .HEX_MODE (1)
    ) dut_hex (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (hbus)
    );

    typedef struct packed {
        logic [7:0] font;
        logic [7:0] hfont;
        logic [3:0] com;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    function automatic logic [7:0] ref_glyph(input logic [3:0] c, input bit hex);
        logic [7:0] g;
        case (c)
            4'h0: g = 8'hC0;
            4'h1: g = 8'hF9;
            4'h2: g = 8'hA4;
            4'h3: g = 8'hB0;
            4'h4: g = 8'h99;
            4'h5: g = 8'h92;
            4'h6: g = 8'h82;
            4'h7: g = 8'hF8;
            4'h8: g = 8'h80;
            4'h9: g = 8'h90;
            4'hA: g = hex ? 8'h88 : 8'hFF;
            4'hB: g = hex ? 8'h83 : 8'hFF;
            4'hC: g = hex ? 8'hC6 : 8'hFF;
            4'hD: g = hex ? 8'hA1 : 8'hFF;
            4'hE: g = hex ? 8'h86 : 8'hFF;
            default: g = hex ? 8'h8E : 8'hFF;
        endcase
        return g;
    endfunction

    task automatic set_in(input logic en, input logic [15:0] v, input logic [3:0] dp);
        bus.i_En     = en;
        bus.i_Value  = v;
        bus.i_Dp     = dp;
        hbus.i_En    = en;
        hbus.i_Value = v;
        hbus.i_Dp    = dp;
    endtask

    task automatic push_exp(input logic [7:0] f, input logic [7:0] hf,
                            input logic [3:0] c, input int n);
        exp_t e;
        e.font  = f;
        e.hfont = hf;
        e.com   = c;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    task automatic push_off(input int n);
        push_exp(8'hFF, 8'hFF, 4'hF, n);
    endtask

    // Expected pins for digits k0..k1 of a frame built from value v / dp, n cycles each.
    task automatic push_digits(input logic [15:0] v, input logic [3:0] dp,
                               input int k0, input int k1, input int n);
        logic [7:0] f, hf;
        logic [3:0] c;
        bit         blank;
        for (int k = k0; k <= k1; k++) begin
            blank = 1'b0;
`ifdef FND_LEADING_ZERO_BLANK_EN
            if (k > 0 && (v >> (4*k)) == 16'h0 && !dp[k]) blank = 1'b1;
`endif
            f  = blank ? 8'hFF : ref_glyph(v[4*k +: 4], 1'b0);
            hf = blank ? 8'hFF : ref_glyph(v[4*k +: 4], 1'b1);
            if (dp[k]) begin
                f[7]  = 1'b0;
                hf[7] = 1'b0;
            end
            c    = 4'hF;
            c[k] = 1'b0;
            push_exp(f, hf, c, n);
        end
    endtask

    task automatic run(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard cycle %0d: no expectation queued", cyc);
            end else begin
                e = exp_q.pop_front();
                checks++;
                assert (bus.o_FND_Font === e.font) else begin
                    errors++;
                    $error("FAIL font cycle %0d: got %h required %h", cyc, bus.o_FND_Font, e.font);
                end
                checks++;
                assert (bus.o_FND_Com === e.com) else begin
                    errors++;
                    $error("FAIL com cycle %0d: got %b required %b", cyc, bus.o_FND_Com, e.com);
                end
                checks++;
                assert (hbus.o_FND_Font === e.hfont) else begin
                    errors++;
                    $error("FAIL hex_font cycle %0d: got %h required %h", cyc, hbus.o_FND_Font, e.hfont);
                end
            end
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held two cycles, then released with the display off.
        rst = 1'b1;
        set_in(1'b0, 16'h0000, 4'h0);
        push_off(2);
        run(2);
        rst = 1'b0;
        push_off(2);
        run(2);

        // Basic scan of 1234, one full frame plus the start of the next.
        set_in(1'b0, 16'h1234, 4'h0);
        push_off(1);
        run(1);
        set_in(1'b1, 16'h1234, 4'h0);
        push_digits(16'h1234, 4'h0, 0, 3, 4);
        push_digits(16'h1234, 4'h0, 0, 0, 4);
        run(20);

        // Value changes mid-frame: rest of frame keeps the old snapshot.
        set_in(1'b1, 16'h5678, 4'h0);
        push_digits(16'h1234, 4'h0, 1, 3, 4);
        push_digits(16'h5678, 4'h0, 0, 3, 4);
        run(28);

        // Hex code with decimal point on digit 0.
        set_in(1'b0, 16'h000A, 4'h1);
        push_off(1);
        run(1);
        set_in(1'b1, 16'h000A, 4'h1);
        push_digits(16'h000A, 4'h1, 0, 3, 4);
        run(16);

        // Leading zeros.
        set_in(1'b0, 16'h0070, 4'h0);
        push_off(1);
        run(1);
        set_in(1'b1, 16'h0070, 4'h0);
        push_digits(16'h0070, 4'h0, 0, 3, 4);
        run(16);

        // Disable during digit 2, re-enable, then reset mid-frame.
        set_in(1'b0, 16'h1234, 4'h0);
        push_off(1);
        run(1);
        set_in(1'b1, 16'h1234, 4'h0);
        push_digits(16'h1234, 4'h0, 0, 1, 4);
        push_digits(16'h1234, 4'h0, 2, 2, 2);
        run(10);
        set_in(1'b0, 16'h1234, 4'h0);
        push_off(2);
        run(2);
        set_in(1'b1, 16'h1234, 4'h0);
        push_digits(16'h1234, 4'h0, 0, 0, 4);
        push_digits(16'h1234, 4'h0, 1, 1, 1);
        run(5);
        rst = 1'b1;
        push_off(2);
        run(2);
        rst = 1'b0;
        push_digits(16'h0000, 4'h0, 0, 3, 4);
        push_digits(16'h1234, 4'h0, 0, 0, 4);
        run(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fnd_scan_controller.md
FND_SCAN_CONTROLLER -- requirements
Module: fnd_scan_controller

Interface
REQ-001 Parameter DIGITS, 4, number of multiplexed 7-segment digits (2..8).
REQ-002 Parameter SCAN_DIV, 100000, i_clk cycles each digit stays lit (>=2).
REQ-003 Parameter HEX_MODE, 0, 1 = codes A..F shown as hex glyphs, 0 = codes A..F shown blank.
REQ-004 i_clk  in  1  single clock; all logic on rising edge.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 i_En  in  1  display enable; 0 = all digits dark.
REQ-007 i_Value  in  4*DIGITS  packed BCD/hex codes; digit k = i_Value[4k+3:4k], digit 0 least significant.
REQ-008 i_Dp  in  DIGITS  decimal point request per digit.
REQ-009 o_FND_Font  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.
REQ-010 o_FND_Com  out  DIGITS  digit commons, active-low, one-hot-low while scanning.

Function
REQ-011 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; scan tick = cycle where count == SCAN_DIV-1.
REQ-012 On each tick the digit index SHALL advance by 1, wrapping DIGITS-1 -> 0.
REQ-013 A snapshot register SHALL capture i_Value and i_Dp on the tick where index wraps DIGITS-1 -> 0, and on every cycle while i_En = 0; a full frame never mixes two input values.
REQ-014 o_FND_Com and o_FND_Font SHALL be registered; they reflect the index one cycle after it changes (latency 1).
REQ-015 With i_En = 1: o_FND_Com = all ones except bit[index] = 0; o_FND_Font = glyph of snapshot digit[index].
REQ-016 Glyphs (dp bit 1): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90.
REQ-017 Codes A..F: HEX_MODE=1 -> 88, 83, C6, A1, 86, 8E; HEX_MODE=0 -> FF.
REQ-018 Snapshot dp bit for the current digit = 1 SHALL clear o_FND_Font[7]; applies to blank glyphs too.
REQ-019 With i_En = 0: prescaler and index held at 0; next cycle o_FND_Font = 8'hFF, o_FND_Com = all ones.
REQ-020 On i_En 0->1, digit 0 SHALL be lit on the following cycle with the value present while disabled, and stay lit SCAN_DIV cycles.

Reset
REQ-021 i_reset = 1 SHALL, on the next edge, set o_FND_Font = 8'hFF, o_FND_Com = all ones, prescaler = 0, index = 0, snapshot = 0.
REQ-022 Reset SHALL take priority over i_En and scan ticks; reset mid-frame abandons the frame, and scanning restarts from digit 0 after release.

Configuration
REQ-023 Macro FND_LEADING_ZERO_BLANK_EN defined: digit k>0 SHALL show FF (dp still honoured) when snapshot digits k..DIGITS-1 are all zero and its dp bit is 0; digit 0 never blanked.
REQ-024 Macro undefined: leading zeros SHALL display as C0; no blanking logic synthesised.

Structure
REQ-025 Shared package fnd_pkg SHALL hold the 8-bit glyph constants (0..9, A..F, blank) and the font width constant.
REQ-026 Glyph lookup SHALL be a combinational sub-module fnd_glyph_lut (4-bit code, HEX_MODE -> 8-bit font); prescaler, index, snapshot and output registers live in fnd_scan_controller.

Verification (DIGITS=4, SCAN_DIV=4, HEX_MODE=0 unless stated)
REQ-027 Assert i_reset 2 cycles -> o_FND_Font = FF, o_FND_Com = 1111; release with i_En=0 -> unchanged.
REQ-028 i_En=1, i_Value=16'h1234, i_Dp=0 -> Com 1110/1101/1011/0111, 4 cycles each, Font 99/B0/A4/F9, then repeats.
REQ-029 Change i_Value 1234->5678 while digit 1 lit -> digits 2,3 still A4,F9; next frame 80/F8/82/92.
REQ-030 i_Value digit0=A, i_Dp=0001 -> Font 7F (HEX_MODE=0); HEX_MODE=1 -> 08.
REQ-031 i_Value=16'h0070, macro defined -> digits 3,2 FF, digit 1 F8, digit 0 C0; macro undefined -> digit 3 C0.
REQ-032 Drop i_En during digit 2 -> next cycle FF/1111; re-enable -> next cycle Com 1110; assert i_reset mid-frame -> FF/1111, restart from digit 0.
